// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: producer A/B handshakes, register file write
// port, decode lookup and the stall statistic.
interface wb_write_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [ADDR_W-1:0] lk_addr1;
    logic [ADDR_W-1:0] lk_addr2;
    logic              lk_hit1;
    logic [DATA_W-1:0] lk_data1;
    logic              lk_hit2;
    logic [DATA_W-1:0] lk_data2;

    logic [31:0]       stall_count;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output lk_addr1, lk_addr2,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  lk_hit1, lk_data1, lk_hit2, lk_data2,
        input  stall_count
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  lk_addr1, lk_addr2,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata,
        output lk_hit1, lk_data1, lk_hit2, lk_data2,
        output stall_count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback queue in front of the register file write port, with a
// pending-write lookup for decode. Optional stall counter under WBQ_STATS_EN.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic             clk,
    input logic             reset,
    wb_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic a_ready, b_ready;
    logic a_store, b_store;
    logic pop;

    // Readiness uses the start-of-cycle count; A owns the last free slot.
    always_comb begin
        a_ready = (count_q <= CNT_W'(DEPTH - 1));
        b_ready = (count_q <= CNT_W'(DEPTH - 2)) ||
                  ((count_q == CNT_W'(DEPTH - 1)) && !bus.a_valid);
        a_store = bus.a_valid && a_ready && (bus.a_addr != '0);
        b_store = bus.b_valid && b_ready && (bus.b_addr != '0);
        pop     = (count_q != '0);
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        tail_d = tail_q;
        if (a_store) begin
            addr_d[tail_d] = bus.a_addr;
            data_d[tail_d] = bus.a_data;
            tail_d         = tail_d + PTR_W'(1);
        end
        if (b_store) begin
            addr_d[tail_d] = bus.b_addr;
            data_d[tail_d] = bus.b_data;
            tail_d         = tail_d + PTR_W'(1);
        end
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        count_d = count_q + CNT_W'(a_store) + CNT_W'(b_store) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.rf_we    = pop;
    assign bus.rf_waddr = pop ? addr_q[head_q] : '0;
    assign bus.rf_wdata = pop ? data_q[head_q] : '0;

    logic              hit1, hit2;
    logic [DATA_W-1:0] ldata1, ldata2;
    logic [PTR_W-1:0]  lk_idx;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        ldata1 = '0;
        ldata2 = '0;
        lk_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((bus.lk_addr1 != '0) && (addr_q[lk_idx] == bus.lk_addr1)) begin
                    hit1   = 1'b1;
                    ldata1 = data_q[lk_idx];
                end
                if ((bus.lk_addr2 != '0) && (addr_q[lk_idx] == bus.lk_addr2)) begin
                    hit2   = 1'b1;
                    ldata2 = data_q[lk_idx];
                end
            end
        end
    end

    assign bus.lk_hit1  = hit1;
    assign bus.lk_data1 = ldata1;
    assign bus.lk_hit2  = hit2;
    assign bus.lk_data2 = ldata2;

`ifdef WBQ_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_evt;

    always_comb begin
        stall_evt = (bus.a_valid && !a_ready) || (bus.b_valid && !b_ready);
        stall_d   = stall_q;
        if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_wb_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [31:0] m_stall = '0;
    bit          m_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending writes, updated at each rising edge.
    task automatic model_step();
        int sz;
        bit ar, br;
        if (reset) begin
            mq.delete();
            m_stall = '0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            sz = mq.size();
            ar = (sz <= DEPTH - 1);
            br = (sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !bus.a_valid);
            if (((bus.a_valid && !ar) || (bus.b_valid && !br)) && (m_stall != 32'hFFFF_FFFF))
                m_stall++;
            if (sz != 0) void'(mq.pop_front());
            if (bus.a_valid && ar && (bus.a_addr != '0))
                mq.push_back('{addr: bus.a_addr, data: bus.a_data});
            if (bus.b_valid && br && (bus.b_addr != '0))
                mq.push_back('{addr: bus.b_addr, data: bus.b_data});
        end
    endtask

    task automatic compare();
        int sz;
        logic exp_we, exp_h1, exp_h2;
        logic [ADDR_W-1:0] exp_wa;
        logic [DATA_W-1:0] exp_wd, exp_d1, exp_d2;
        logic [31:0] exp_stall;
        sz     = mq.size();
        exp_we = (sz != 0);
        exp_wa = (sz != 0) ? mq[0].addr : '0;
        exp_wd = (sz != 0) ? mq[0].data : '0;
        exp_h1 = 1'b0; exp_d1 = '0;
        exp_h2 = 1'b0; exp_d2 = '0;
        foreach (mq[i]) begin
            if (bus.lk_addr1 != '0 && mq[i].addr == bus.lk_addr1) begin exp_h1 = 1'b1; exp_d1 = mq[i].data; end
            if (bus.lk_addr2 != '0 && mq[i].addr == bus.lk_addr2) begin exp_h2 = 1'b1; exp_d2 = mq[i].data; end
        end
`ifdef WBQ_STATS_EN
        exp_stall = m_stall;
`else
        exp_stall = '0;
`endif
        check("a_ready", 32'(bus.a_ready), 32'(sz <= DEPTH - 1));
        check("b_ready", 32'(bus.b_ready), 32'((sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !bus.a_valid)));
        check("rf_we", 32'(bus.rf_we), 32'(exp_we));
        check("rf_waddr", 32'(bus.rf_waddr), 32'(exp_wa));
        check("rf_wdata", bus.rf_wdata, exp_wd);
        check("lk_hit1", 32'(bus.lk_hit1), 32'(exp_h1));
        check("lk_data1", bus.lk_data1, exp_d1);
        check("lk_hit2", 32'(bus.lk_hit2), 32'(exp_h2));
        check("lk_data2", bus.lk_data2, exp_d2);
        check("stall_count", bus.stall_count, exp_stall);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_ok) compare();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1);
    end

    int a_seq = 0;
    int b_seq = 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_a();
        a_seq++;
        bus.a_addr = ADDR_W'((a_seq % 7) + 1);
        bus.a_data = 32'hA000_0000 + 32'(a_seq);
    endtask

    task automatic next_b();
        b_seq++;
        bus.b_addr = ADDR_W'(b_seq % 5);
        bus.b_data = 32'hB000_0000 + 32'(b_seq);
    endtask

    // Producers keep addr/data stable until their beat is accepted.
    task automatic fill(input int n, input bit gate_a);
        bit acc_a, acc_b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            tick();
            if (acc_a) next_a();
            if (acc_b) next_b();
            if (gate_a) bus.a_valid = (i % 3 != 2);
            if (i == n / 2) begin
                bus.lk_addr1 = 5'd3;
                bus.lk_addr2 = 5'd1;
            end
        end
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.lk_addr1 = '0;  bus.lk_addr2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("idle_rf_we", 32'(bus.rf_we), 32'd0);
            check("idle_a_ready", 32'(bus.a_ready), 32'd1);
            check("idle_b_ready", 32'(bus.b_ready), 32'd1);
            check("idle_lk_hit1", 32'(bus.lk_hit1), 32'd0);
        end

        // Single write from A
        tick();
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h0000_00AA; bus.lk_addr1 = 5'd5;
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("single_rf_we", 32'(bus.rf_we), 32'd1);
        check("single_rf_waddr", 32'(bus.rf_waddr), 32'd5);
        check("single_rf_wdata", bus.rf_wdata, 32'h0000_00AA);
        check("single_lk_hit1", 32'(bus.lk_hit1), 32'd1);
        check("single_lk_data1", bus.lk_data1, 32'h0000_00AA);
        tick();
        @(negedge clk);
        check("single_after_rf_we", 32'(bus.rf_we), 32'd0);
        check("single_after_lk_hit1", 32'(bus.lk_hit1), 32'd0);

        // A and B accepted together, same destination
        tick();
        bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h22;
        bus.lk_addr1 = 5'd3;
        tick();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk);
        check("dual_first_waddr", 32'(bus.rf_waddr), 32'd3);
        check("dual_first_wdata", bus.rf_wdata, 32'h11);
        check("dual_first_lk_data1", bus.lk_data1, 32'h22);
        tick();
        @(negedge clk);
        check("dual_second_wdata", bus.rf_wdata, 32'h22);
        check("dual_second_lk_data1", bus.lk_data1, 32'h22);
        tick();
        @(negedge clk);
        check("dual_drained_rf_we", 32'(bus.rf_we), 32'd0);

        // x0 write is accepted but never stored
        tick();
        bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hDEAD; bus.lk_addr1 = 5'd0;
        @(negedge clk);
        check("x0_a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("x0_rf_we", 32'(bus.rf_we), 32'd0);
        check("x0_lk_hit1", 32'(bus.lk_hit1), 32'd0);

        // Sustained traffic: queue settles at 3 entries, B stalls from the third edge
        tick();
        next_a(); next_b();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.lk_addr1 = 5'd2; bus.lk_addr2 = 5'd4;
        fill(7, 1'b0);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("prereset_rf_we", 32'(bus.rf_we), 32'd1);
`ifdef WBQ_STATS_EN
        check("prereset_stall_count", bus.stall_count, 32'd5);
`endif
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("postreset_rf_we", 32'(bus.rf_we), 32'd0);
        check("postreset_lk_hit1", 32'(bus.lk_hit1), 32'd0);
        check("postreset_lk_hit2", 32'(bus.lk_hit2), 32'd0);
        check("postreset_stall_count", bus.stall_count, 32'd0);

        // Longer mixed traffic across pointer wrap, including B x0 beats
        tick();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        fill(24, 1'b1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("final_rf_we", 32'(bus.rf_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
